// File: rtl/soc_control_ext_if.sv
// Bus access types, write-resolution helper and the SoC memory-bus interface
// shared by soc_control_ext and its bus masters.
package soc_ctl_pkg;
   typedef enum logic [1:0] {
      ACC_MAIN   = 2'd0,
      ACC_SET    = 2'd1,
      ACC_CLEAR  = 2'd2,
      ACC_TOGGLE = 2'd3
   } reg_access_t;

   localparam int unsigned CLK_MAIN_DIVIDER = 8;

   // Resolves a bus write against the register's current value.
   function automatic logic [31:0] writeval(input reg_access_t acc,
                                            input logic [31:0] cur,
                                            input logic [31:0] wdata);
      case (acc)
         ACC_SET:    return cur | wdata;
         ACC_CLEAR:  return cur & ~wdata;
         ACC_TOGGLE: return cur ^ wdata;
         default:    return wdata;
      endcase
   endfunction
endpackage

interface SoC_MemBus;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;

   modport Slave  (input req, we, addr, wdata, output rdata, rvalid);
   modport Master (output req, we, addr, wdata, input rdata, rvalid);
endinterface

// File: rtl/soc_control_ext.sv
// SoC controller: core halt/reset, stretched SoC reset, interrupt controller.
// Optional watchdog enabled by defining SOCCTL_WATCHDOG_EN.
module soc_control_ext
   import soc_ctl_pkg::*;
#(
   parameter int unsigned BUS_LATENCY = 1,
   parameter int unsigned NUM_INTS    = 32,
   parameter int unsigned RESET_HOLD  = 16
) (
   input  logic                clk,
   input  logic                res_n,
   output logic                core_halt,
   output logic                core_res,
   output logic                soc_res,
   output logic [15:0]         control_flags,
   output logic                irq,
   input  logic [NUM_INTS-1:0] int_triggers,
   SoC_MemBus.Slave            mem_bus
);

   localparam logic [7:0]  REG_CONTROL   = 8'd0;
   localparam logic [7:0]  REG_INT_EN    = 8'd1;
   localparam logic [7:0]  REG_INT_FLAGS = 8'd2;
   localparam logic [7:0]  REG_CLK_FREQ  = 8'd3;
   localparam logic [7:0]  REG_INT_MODE  = 8'd4;
   localparam logic [7:0]  REG_INT_ID    = 8'd5;
   localparam logic [7:0]  REG_WDT_LOAD  = 8'd6;
   localparam logic [7:0]  REG_WDT_COUNT = 8'd7;
   localparam logic [15:0] HOLD_INIT     = 16'(RESET_HOLD);
   localparam logic [31:0] CLK_FREQ      = 32'(800_000_000 / CLK_MAIN_DIVIDER);

   typedef logic [NUM_INTS-1:0] ivec_t;

   logic        ctl_halt, ctl_core_res, ctl_gie;
   logic [15:0] ctl_flags;
   logic [15:0] hold_cnt;
   ivec_t       int_en, int_flags, int_mode, trig_q, trig_qq;
   ivec_t       edge_set, w1c, flags_nxt, pend;
   logic [5:0]  int_id;

   logic        wdt_fired, wdt_expire;
   logic [15:0] wdt_load, wdt_count;

   logic [7:0]  reg_idx;
   reg_access_t acc;
   logic        wr, rd;
   logic [31:0] reg_val, wval;

   assign reg_idx = mem_bus.addr[11:4];
   assign acc     = reg_access_t'(mem_bus.addr[3:2]);
   assign wr      = mem_bus.req & mem_bus.we;
   assign rd      = mem_bus.req & ~mem_bus.we;
   assign wval    = writeval(acc, reg_val, mem_bus.wdata);

   logic wr_ctl, wr_en, wr_flags, wr_mode;
   assign wr_ctl   = wr && (reg_idx == REG_CONTROL);
   assign wr_en    = wr && (reg_idx == REG_INT_EN);
   assign wr_flags = wr && (reg_idx == REG_INT_FLAGS);
   assign wr_mode  = wr && (reg_idx == REG_INT_MODE);

   always_comb begin
      // NOTE: default first so every path assigns reg_val and no latch is inferred.
      reg_val = '0;
      case (reg_idx)
         REG_CONTROL:   reg_val = {ctl_flags, 11'd0, wdt_fired, ctl_gie, 1'b0,
                                   ctl_core_res, ctl_halt};
         REG_INT_EN:    reg_val = 32'(int_en);
         REG_INT_FLAGS: reg_val = 32'(int_flags);
         REG_CLK_FREQ:  reg_val = CLK_FREQ;
         REG_INT_MODE:  reg_val = 32'(int_mode);
         REG_INT_ID:    reg_val = {26'd0, int_id};
         REG_WDT_LOAD:  reg_val = {16'd0, wdt_load};
         REG_WDT_COUNT: reg_val = {16'd0, wdt_count};
         default:       reg_val = '0;
      endcase
   end

   // Edge sources are sticky with write-1-clear (a same-cycle edge wins);
   // level sources simply follow the first sync stage.
   always_comb begin
      edge_set  = trig_q & ~trig_qq;
      w1c       = wr_flags ? wval[NUM_INTS-1:0] : '0;
      flags_nxt = (int_mode & ((int_flags & ~w1c) | edge_set)) | (~int_mode & trig_q);
   end

   always_comb begin
      pend   = int_flags & int_en;
      int_id = '0;
      for (int i = int'(NUM_INTS) - 1; i >= 0; i--)
         if (pend[i]) int_id = 6'(i + 1);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments only, so every register samples pre-edge values.
      if (!res_n) begin
         ctl_halt     <= 1'b0;
         ctl_core_res <= 1'b0;
         ctl_gie      <= 1'b1;
         ctl_flags    <= '0;
         int_en       <= '0;
         int_flags    <= '0;
         int_mode     <= '0;
         trig_q       <= '0;
         trig_qq      <= '0;
         hold_cnt     <= '0;
      end else begin
         trig_q    <= int_triggers;
         trig_qq   <= trig_q;
         int_flags <= flags_nxt;
         if (wr_ctl) begin
            ctl_halt     <= wval[0];
            ctl_core_res <= wval[1];
            ctl_gie      <= wval[3];
            ctl_flags    <= wval[31:16];
         end
         if (wr_en)   int_en   <= wval[NUM_INTS-1:0];
         if (wr_mode) int_mode <= wval[NUM_INTS-1:0];

         if ((wr_ctl && wval[2]) || wdt_expire) hold_cnt <= HOLD_INIT;
         else if (hold_cnt != 16'd0)            hold_cnt <= hold_cnt - 16'd1;

         // While the SoC reset is being stretched, the core-facing state is held
         // at reset values; flags, mode and watchdog config survive.
         if (hold_cnt != 16'd0) begin
            ctl_halt     <= 1'b0;
            ctl_core_res <= 1'b0;
            ctl_gie      <= 1'b1;
            int_en       <= '0;
            int_flags    <= '0;
         end
      end
   end

`ifdef SOCCTL_WATCHDOG_EN
   logic wr_load, wr_count, wdt_run;
   assign wr_load    = wr && (reg_idx == REG_WDT_LOAD);
   assign wr_count   = wr && (reg_idx == REG_WDT_COUNT);
   assign wdt_run    = (wdt_load != 16'd0) && !ctl_halt && (hold_cnt == 16'd0);
   assign wdt_expire = wdt_run && (wdt_count == 16'd1) && !wr_load && !wr_count;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         wdt_load  <= '0;
         wdt_count <= '0;
         wdt_fired <= 1'b0;
      end else begin
         if (wr_ctl && wval[4]) wdt_fired <= 1'b0;
         if (wdt_expire)        wdt_fired <= 1'b1;
         if (wr_load) begin
            wdt_load  <= wval[15:0];
            wdt_count <= wval[15:0];
         end else if (wr_count || wdt_expire) begin
            wdt_count <= wdt_load;
         end else if (wdt_run && wdt_count != 16'd0) begin
            wdt_count <= wdt_count - 16'd1;
         end
      end
   end
`else
   assign wdt_expire = 1'b0;
   assign wdt_fired  = 1'b0;
   assign wdt_load   = '0;
   assign wdt_count  = '0;
`endif

   // Read path: the value is captured when the read is accepted and then
   // delayed so that rdata appears BUS_LATENCY cycles later.
   logic [31:0]            rd_pipe [BUS_LATENCY];
   logic [BUS_LATENCY-1:0] rv_pipe;

   always_ff @(posedge clk) begin
      // NOTE: only the valid bits are reset; data stages are qualified by them.
      if (!res_n) rv_pipe <= '0;
      else begin
         rv_pipe[0] <= rd;
         for (int i = int'(BUS_LATENCY) - 1; i > 0; i--) rv_pipe[i] <= rv_pipe[i-1];
      end
      rd_pipe[0] <= (acc == ACC_MAIN) ? reg_val : '0;
      for (int i = int'(BUS_LATENCY) - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
   end

   assign mem_bus.rdata  = rd_pipe[BUS_LATENCY-1];
   assign mem_bus.rvalid = rv_pipe[BUS_LATENCY-1];

   assign core_halt     = res_n & ctl_halt;
   assign core_res      = !res_n | ctl_core_res;
   assign soc_res       = !res_n | (hold_cnt != 16'd0);
   assign control_flags = res_n ? ctl_flags : 16'd0;
   assign irq           = res_n & ctl_gie & (|(int_flags & int_en));

   logic unused_bits;
   assign unused_bits = ^{mem_bus.addr[31:12], mem_bus.addr[1:0], wval};

endmodule

// File: tb/tb_soc_control_ext.sv
// Directed self-checking bench for soc_control_ext (NUM_INTS=4, RESET_HOLD=16).
module tb_soc_control_ext;
   logic        clk = 1'b0;
   logic        res_n;
   logic        core_halt, core_res, soc_res, irq;
   logic [15:0] control_flags;
   logic [3:0]  trig;
   logic [31:0] rv;
   int          passed = 0;
   int          failed = 0;
   int          total  = 0;
   int          cnt;

   SoC_MemBus bus ();

   soc_control_ext #(.BUS_LATENCY(1), .NUM_INTS(4), .RESET_HOLD(16)) dut (
      .clk           (clk),
      .res_n         (res_n),
      .core_halt     (core_halt),
      .core_res      (core_res),
      .soc_res       (soc_res),
      .control_flags (control_flags),
      .irq           (irq),
      .int_triggers  (trig),
      .mem_bus       (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] adr(input logic [7:0] idx, input logic [1:0] acc);
      return {20'd0, idx, acc, 2'b00};
   endfunction

   task automatic write_reg(input logic [7:0] idx, input logic [1:0] acc, input logic [31:0] d);
      bus.req = 1'b1; bus.we = 1'b1; bus.addr = adr(idx, acc); bus.wdata = d;
      cyc(1);
      bus.req = 1'b0; bus.we = 1'b0;
   endtask

   task automatic read_reg(input logic [7:0] idx, input logic [1:0] acc, output logic [31:0] d);
      int n = 0;
      bus.req = 1'b1; bus.we = 1'b0; bus.addr = adr(idx, acc);
      cyc(1);
      bus.req = 1'b0;
      while (!bus.rvalid && n < 8) begin cyc(1); n++; end
      check("rvalid", {31'd0, bus.rvalid}, 32'd1);
      d = bus.rdata;
   endtask

   initial begin
      res_n = 1'b0; trig = '0;
      bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

      // Reset
      cyc(1);
      check("rst_soc_res", {31'd0, soc_res}, 32'd1);
      check("rst_core_res", {31'd0, core_res}, 32'd1);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_core_halt", {31'd0, core_halt}, 32'd0);
      check("rst_flags_out", {16'd0, control_flags}, 32'd0);
      cyc(1);
      res_n = 1'b1;
      cyc(1);
      check("post_rst_soc_res", {31'd0, soc_res}, 32'd0);
      check("post_rst_core_res", {31'd0, core_res}, 32'd0);
      read_reg(8'd0, 2'd0, rv); check("rst_control", rv, 32'h0000_0008);
      read_reg(8'd5, 2'd0, rv); check("rst_int_id", rv, 32'd0);
      read_reg(8'd3, 2'd0, rv); check("clk_freq", rv, 32'h05F5_E100);
      read_reg(8'd0, 2'd1, rv); check("non_main_read", rv, 32'd0);

      // Source-count masking
      write_reg(8'd1, 2'd0, 32'hFFFF_FFFF);
      read_reg(8'd1, 2'd0, rv); check("int_en_mask", rv, 32'h0000_000F);
      check("mask_irq", {31'd0, irq}, 32'd0);

      // Edge source 2
      write_reg(8'd4, 2'd0, 32'h4);
      write_reg(8'd1, 2'd0, 32'h5);
      trig = 4'h4;
      cyc(1);
      trig = 4'h0;
      check("edge_irq_early", {31'd0, irq}, 32'd0);
      cyc(1);
      check("edge_irq", {31'd0, irq}, 32'd1);
      read_reg(8'd2, 2'd0, rv); check("edge_flags", rv, 32'h4);
      read_reg(8'd5, 2'd0, rv); check("edge_int_id", rv, 32'd3);
      write_reg(8'd2, 2'd0, 32'h4);
      check("w1c_irq", {31'd0, irq}, 32'd0);
      read_reg(8'd2, 2'd0, rv); check("w1c_flags", rv, 32'h0);

      // Level source 0 plus edge source 2, priority and GIE gating
      trig = 4'h5;
      cyc(2);
      read_reg(8'd5, 2'd0, rv); check("prio_int_id", rv, 32'd1);
      check("prio_irq", {31'd0, irq}, 32'd1);
      write_reg(8'd0, 2'd0, 32'h0);
      check("gie_off_irq", {31'd0, irq}, 32'd0);
      read_reg(8'd5, 2'd0, rv); check("gie_off_int_id", rv, 32'd1);
      trig = 4'h4;
      cyc(2);
      read_reg(8'd5, 2'd0, rv); check("level_drop_int_id", rv, 32'd3);
      read_reg(8'd2, 2'd0, rv); check("level_drop_flags", rv, 32'h4);
      write_reg(8'd2, 2'd0, 32'h4);
      trig = 4'h0;
      cyc(2);

      // Same-cycle edge set and software clear: set wins
      trig = 4'h4;
      cyc(1);
      trig = 4'h0;
      write_reg(8'd2, 2'd0, 32'h4);
      read_reg(8'd2, 2'd0, rv); check("set_wins", rv, 32'h4);
      check("set_wins_gie_off", {31'd0, irq}, 32'd0);
      write_reg(8'd0, 2'd0, 32'h8);
      check("gie_on_irq", {31'd0, irq}, 32'd1);
      write_reg(8'd2, 2'd0, 32'h4);
      check("final_clear_irq", {31'd0, irq}, 32'd0);

      // Stretched SoC reset
      write_reg(8'd0, 2'd0, 32'hABCD_0009);
      check("halt_out", {31'd0, core_halt}, 32'd1);
      check("flags_out", {16'd0, control_flags}, 32'h0000_ABCD);
      read_reg(8'd0, 2'd0, rv); check("control_rb", rv, 32'hABCD_0009);
      write_reg(8'd0, 2'd1, 32'h4);
      cnt = 0;
      while (soc_res && cnt < 100) begin cnt++; cyc(1); end
      check("hold_len", cnt, 32'd16);
      read_reg(8'd0, 2'd0, rv); check("control_after_hold", rv, 32'hABCD_0008);
      read_reg(8'd1, 2'd0, rv); check("int_en_after_hold", rv, 32'h0);
      read_reg(8'd4, 2'd0, rv); check("int_mode_kept", rv, 32'h4);
      check("halt_after_hold", {31'd0, core_halt}, 32'd0);

      // Rewrite during hold reloads the counter
      write_reg(8'd0, 2'd1, 32'h4);
      cyc(5);
      write_reg(8'd0, 2'd1, 32'h4);
      cnt = 0;
      while (soc_res && cnt < 100) begin cnt++; cyc(1); end
      check("hold_reload_len", cnt, 32'd16);

`ifdef SOCCTL_WATCHDOG_EN
      write_reg(8'd0, 2'd0, 32'h8);
      write_reg(8'd6, 2'd0, 32'd10);
      cnt = 0;
      while (!soc_res && cnt < 100) begin cnt++; cyc(1); end
      check("wdt_fire_delay", cnt, 32'd10);
      cnt = 0;
      while (soc_res && cnt < 100) begin cnt++; cyc(1); end
      check("wdt_hold_len", cnt, 32'd16);
      read_reg(8'd0, 2'd0, rv); check("wdt_fired", rv, 32'h18);
      write_reg(8'd0, 2'd0, 32'h18);
      for (int k = 0; k < 6; k++) begin
         write_reg(8'd7, 2'd0, 32'd0);
         cyc(7);
      end
      check("kick_soc_res", {31'd0, soc_res}, 32'd0);
      read_reg(8'd0, 2'd0, rv); check("kick_not_fired", rv, 32'h8);
      write_reg(8'd7, 2'd0, 32'd0);
      write_reg(8'd0, 2'd0, 32'h9);
      cyc(30);
      read_reg(8'd7, 2'd0, rv); check("halt_freeze", rv, 32'd9);
      write_reg(8'd6, 2'd0, 32'd0);
      write_reg(8'd0, 2'd0, 32'h8);
`else
      write_reg(8'd6, 2'd0, 32'h55);
      read_reg(8'd6, 2'd0, rv); check("no_wdt_load", rv, 32'd0);
      cyc(20);
      check("no_wdt_soc_res", {31'd0, soc_res}, 32'd0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
